// File: rtl/psum_pkg.sv
// psum_pkg: shared constants and S2 pipeline register type for the psum scratchpad.
package psum_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH = 32;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_ADDR_W = 16;
  typedef struct packed {
    logic valid;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] sum;
  } s2_t;
endpackage

// File: rtl/psum_acc_add.sv
// psum_acc_add: accumulate adder; PSUM_SAT_EN selects signed saturation instead of wrap-around.
module psum_acc_add import psum_pkg::*; #(
  parameter int W = DEF_DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);
  logic [W-1:0] raw;
  assign raw = a + b;
`ifdef PSUM_SAT_EN
  assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
  assign sum = ovf ? {a[W-1], {(W-1){~a[W-1]}}} : raw;
`else
  assign ovf = 1'b0;
  assign sum = raw;
`endif
endmodule

// File: rtl/psum_spad_acc.sv
// psum_spad_acc: partial-sum scratchpad with append, random read and pipelined in-place accumulate.
// Build with PSUM_SAT_EN defined for saturating accumulate.
module psum_spad_acc import psum_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              acc_en,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              err
);
  logic [DATA_W-1:0] mem [DEPTH];
  s2_t s2;
  logic [DATA_W-1:0] s2_sum, op, sum;
  logic ovf, wr_ok, acc_ok, rd_ok, acc_hit, rd_hit;
  assign s2_sum = DATA_W'(s2.sum);
  assign full = count == (ADDR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign wr_ok = wr_en && !full;
  assign acc_ok = acc_en && ({1'b0, acc_addr} < count);
  assign rd_ok = {1'b0, rd_addr} < count;
  assign acc_hit = s2.valid && s2.addr == MAX_ADDR_W'(acc_addr);
  assign rd_hit = s2.valid && s2.addr == MAX_ADDR_W'(rd_addr);
  // back-to-back accumulates to one entry take the not-yet-written sum
  assign op = acc_hit ? s2_sum : mem[acc_addr];
  psum_acc_add #(.W(DATA_W)) u_add (
    .a(op),
    .b(acc_data),
    .sum(sum),
    .ovf(ovf)
  );
  always_ff @(posedge clk)
    if (rst || clr) begin
      count <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      err <= 1'b0;
      s2 <= '0;
    end else begin
      if (wr_ok) count <= count + (ADDR_W+1)'(1);
      rd_valid <= rd_en;
      if (rd_en) rd_data <= !rd_ok ? '0 : rd_hit ? s2_sum : mem[rd_addr];
      s2 <= '{valid: acc_ok, addr: MAX_ADDR_W'(acc_addr), sum: MAX_DATA_W'(sum)};
      if ((wr_en && full) || (rd_en && !rd_ok) || (acc_en && !acc_ok) || (acc_ok && ovf)) err <= 1'b1;
    end
  // append targets count and accumulate targets < count, so the two writes never collide
  always_ff @(posedge clk)
    if (!rst && !clr) begin
      if (wr_ok) mem[count[ADDR_W-1:0]] <= wr_data;
      if (s2.valid) mem[ADDR_W'(s2.addr)] <= s2_sum;
    end
endmodule
